// File: rtl/cache_mem_arbiter_if.sv
// Cache-side and bridge-side signal bundle for the cache/bridge read arbiter.
// slave = arbiter view, master = environment (caches + bridge) view.
interface cache_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // icache read channel
    logic              i_rd_req;
    logic [2:0]        i_rd_type;
    logic [ADDR_W-1:0] i_rd_addr;
    logic              i_rd_rdy;
    logic              i_ret_valid;
    logic              i_ret_last;
    logic [DATA_W-1:0] i_ret_data;
    // dcache read channel
    logic              d_rd_req;
    logic [2:0]        d_rd_type;
    logic [ADDR_W-1:0] d_rd_addr;
    logic              d_rd_rdy;
    logic              d_ret_valid;
    logic              d_ret_last;
    logic [DATA_W-1:0] d_ret_data;
    // dcache write channel
    logic              d_wr_req;
    logic [2:0]        d_wr_type;
    logic [ADDR_W-1:0] d_wr_addr;
    logic [3:0]        d_wr_wstrb;
    logic [127:0]      d_wr_data;
    logic              d_wr_rdy;
    // bridge read channel
    logic              mem_rd_req;
    logic [2:0]        mem_rd_type;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic              mem_rd_rdy;
    logic              mem_ret_valid;
    logic              mem_ret_last;
    logic [DATA_W-1:0] mem_ret_data;
    // bridge write channel
    logic              mem_wr_req;
    logic [2:0]        mem_wr_type;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [3:0]        mem_wr_wstrb;
    logic [127:0]      mem_wr_data;
    logic              mem_wr_rdy;
    // status
    logic              busy;

    modport slave (
        input  i_rd_req, i_rd_type, i_rd_addr,
        output i_rd_rdy, i_ret_valid, i_ret_last, i_ret_data,
        input  d_rd_req, d_rd_type, d_rd_addr,
        output d_rd_rdy, d_ret_valid, d_ret_last, d_ret_data,
        input  d_wr_req, d_wr_type, d_wr_addr, d_wr_wstrb, d_wr_data,
        output d_wr_rdy,
        output mem_rd_req, mem_rd_type, mem_rd_addr,
        input  mem_rd_rdy, mem_ret_valid, mem_ret_last, mem_ret_data,
        output mem_wr_req, mem_wr_type, mem_wr_addr, mem_wr_wstrb, mem_wr_data,
        input  mem_wr_rdy,
        output busy
    );

    modport master (
        output i_rd_req, i_rd_type, i_rd_addr,
        input  i_rd_rdy, i_ret_valid, i_ret_last, i_ret_data,
        output d_rd_req, d_rd_type, d_rd_addr,
        input  d_rd_rdy, d_ret_valid, d_ret_last, d_ret_data,
        output d_wr_req, d_wr_type, d_wr_addr, d_wr_wstrb, d_wr_data,
        input  d_wr_rdy,
        input  mem_rd_req, mem_rd_type, mem_rd_addr,
        output mem_rd_rdy, mem_ret_valid, mem_ret_last, mem_ret_data,
        input  mem_wr_req, mem_wr_type, mem_wr_addr, mem_wr_wstrb, mem_wr_data,
        output mem_wr_rdy,
        input  busy
    );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Shares the single bridge read channel between icache (port 0) and dcache
// (port 1). One read in flight at a time; return beats are steered to the
// owner. The dcache write channel is a plain pass-through.
module cache_mem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int PRIO_MODE = 0     // 0: round-robin, 1: dcache wins ties
) (
    input  logic                 clk,
    input  logic                 rst,
    cache_mem_arbiter_if.slave   bus
);
    typedef enum logic [2:0] {
        IDLE = 3'b001,
        REQ  = 3'b010,
        RET  = 3'b100
    } state_t;

    state_t state_q;
    logic   grant_q;    // 0 = icache, 1 = dcache
    logic   last_q;     // owner of the last accepted read

    logic win_d;
    logic gnt_req;
    logic accept;
    logic in_req;
    logic in_ret;

    assign in_req  = (state_q == REQ);
    assign in_ret  = (state_q == RET);
    // The granted cache must still be asking; a dropped request is an abort.
    assign gnt_req = grant_q ? bus.d_rd_req : bus.i_rd_req;
    assign accept  = in_req && gnt_req && bus.mem_rd_rdy;

    // Pick the winner for the next transaction from the current requests.
    always_comb begin
        win_d = bus.d_rd_req;
        if (bus.i_rd_req && bus.d_rd_req)
            win_d = (PRIO_MODE != 0) ? 1'b1 : ~last_q;
    end

    // Transaction FSM: grant in IDLE, issue in REQ, drain beats in RET.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;    // icache wins the first round-robin tie
        end else begin
            case (state_q)
                IDLE: if (bus.i_rd_req || bus.d_rd_req) begin
                    grant_q <= win_d;
                    state_q <= REQ;
                end
                REQ: begin
                    if (!gnt_req) begin
                        state_q <= IDLE;
                    end else if (bus.mem_rd_rdy) begin
                        last_q  <= grant_q;
                        state_q <= RET;
                    end
                end
                RET: if (bus.mem_ret_valid && bus.mem_ret_last)
                    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Read request to the bridge is a mux of the granted cache's request.
    assign bus.mem_rd_req  = in_req && gnt_req;
    assign bus.mem_rd_type = in_req ? (grant_q ? bus.d_rd_type : bus.i_rd_type) : 3'b000;
    assign bus.mem_rd_addr = in_req ? (grant_q ? bus.d_rd_addr : bus.i_rd_addr) : '0;
    assign bus.i_rd_rdy    = accept && !grant_q;
    assign bus.d_rd_rdy    = accept &&  grant_q;

    // Return beats only reach the owner, and only while in RET (stray beats drop).
    assign bus.i_ret_valid = in_ret && !grant_q && bus.mem_ret_valid;
    assign bus.i_ret_last  = in_ret && !grant_q && bus.mem_ret_last;
    assign bus.d_ret_valid = in_ret &&  grant_q && bus.mem_ret_valid;
    assign bus.d_ret_last  = in_ret &&  grant_q && bus.mem_ret_last;
    assign bus.i_ret_data  = in_ret ? bus.mem_ret_data : '0;
    assign bus.d_ret_data  = in_ret ? bus.mem_ret_data : '0;

    // Write channel bypasses the FSM entirely.
    assign bus.mem_wr_req   = bus.d_wr_req;
    assign bus.mem_wr_type  = bus.d_wr_type;
    assign bus.mem_wr_addr  = bus.d_wr_addr;
    assign bus.mem_wr_wstrb = bus.d_wr_wstrb;
    assign bus.mem_wr_data  = bus.d_wr_data;
    assign bus.d_wr_rdy     = bus.mem_wr_rdy;

    assign bus.busy = (state_q != IDLE);
endmodule
